// File: rtl/fc8_tilemap_def_port.sv
// Tilemap definition RAM, responder side.
// The graphics unit reads every cycle it asks, with one cycle of latency. The CPU reaches the RAM
// through an SFR window (address latch, auto-increment data port, status). CPU accesses only use
// cycles the graphics unit leaves free, so the RAM stays single-ported.
// Optional build macro FC8_TMDEF_VBLANK_LOCK_EN: CPU writes commit only during vblank, and
// STATUS bit3 reflects vblank.
module fc8_tilemap_def_port #(
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned DEPTH      = 2048,
    parameter bit          RESET_INC2 = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_gfx_req,
    input  logic [15:0] i_gfx_addr,
    output logic [7:0]  o_gfx_data,
    input  logic        i_vblank,
    input  logic        i_sfr_sel,
    input  logic [1:0]  i_sfr_reg,
    input  logic        i_sfr_wr,
    input  logic        i_sfr_rd,
    input  logic [7:0]  i_sfr_wdata,
    output logic [7:0]  o_sfr_rdata,
    output logic        o_busy
);

    typedef enum logic [1:0] {StIdle, StWrPend, StRdPend} state_e;

    logic [7:0]        r_ram [DEPTH];
    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_cpu_addr;
    logic              r_inc2;
    logic [7:0]        r_rbuf;
    logic [7:0]        r_wbuf;
    logic              r_collision;
    logic [7:0]        r_gfx_data;

    logic [ADDR_W-1:0] w_gfx_idx;
    logic [ADDR_W-1:0] w_cpu_idx;
    logic [ADDR_W-1:0] w_ram_idx;
    logic [ADDR_W-1:0] w_cpu_inc;
    logic              w_busy;
    logic              w_sfr_wr;
    logic              w_sfr_rd;
    logic              w_lo_wr;
    logic              w_hi_wr;
    logic              w_data_wr;
    logic              w_data_rd;
    logic              w_stat_rd;
    logic              w_collide;
    logic              w_commit_ok;
    logic              w_status_b3;
    logic              w_commit;
    logic              w_fetch;

`ifdef FC8_TMDEF_VBLANK_LOCK_EN
    assign w_commit_ok = i_vblank;
    assign w_status_b3 = i_vblank;
`else
    // vblank does not gate commits in this build; OR-ing keeps the port referenced
    assign w_commit_ok = 1'b1 | i_vblank;
    assign w_status_b3 = 1'b0;
`endif

    assign w_gfx_idx = ADDR_W'(32'(i_gfx_addr) % DEPTH);
    assign w_cpu_idx = ADDR_W'(32'(r_cpu_addr) % DEPTH);
    // Graphics owns the RAM whenever it requests; the CPU side only acts when it does not
    assign w_ram_idx = i_gfx_req ? w_gfx_idx : w_cpu_idx;
    assign w_cpu_inc = ADDR_W'((32'(r_cpu_addr) + (r_inc2 ? 32'd2 : 32'd1)) % DEPTH);

    assign w_busy    = (r_state != StIdle);
    // A simultaneous write and read is treated as a write only
    assign w_sfr_wr  = i_sfr_sel & i_sfr_wr;
    assign w_sfr_rd  = i_sfr_sel & i_sfr_rd & ~i_sfr_wr;
    assign w_lo_wr   = w_sfr_wr && (i_sfr_reg == 2'd0);
    assign w_hi_wr   = w_sfr_wr && (i_sfr_reg == 2'd1);
    assign w_data_wr = w_sfr_wr && (i_sfr_reg == 2'd2);
    assign w_data_rd = w_sfr_rd && (i_sfr_reg == 2'd2);
    assign w_stat_rd = w_sfr_rd && (i_sfr_reg == 2'd3);
    assign w_collide = (w_data_wr || w_data_rd) && w_busy;
    assign w_commit  = (r_state == StWrPend) && !i_gfx_req && w_commit_ok;
    assign w_fetch   = (r_state == StRdPend) && !i_gfx_req;

    assign o_busy     = w_busy;
    assign o_gfx_data = r_gfx_data;

    // Next-state: data-port accesses start a pending op; an ADDR_HI write forces a prefetch
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_data_wr) begin
                    w_state_next = StWrPend;
                end else if (w_data_rd) begin
                    w_state_next = StRdPend;
                end
            end
            StWrPend: if (w_commit) w_state_next = StRdPend;
            StRdPend: if (w_fetch)  w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
        if (w_hi_wr) begin
            w_state_next = StRdPend;
        end
    end

    // SFR read mux, combinational so data is valid in the strobe cycle
    always_comb begin
        o_sfr_rdata = 8'h00;
        if (w_sfr_rd) begin
            unique case (i_sfr_reg)
                2'd0: o_sfr_rdata = r_cpu_addr[7:0];
                2'd1: o_sfr_rdata = {r_inc2, 7'(r_cpu_addr >> 8)};
                2'd2: o_sfr_rdata = r_rbuf;
                2'd3: o_sfr_rdata = {4'b0, w_status_b3, r_inc2, r_collision, w_busy};
                default: o_sfr_rdata = 8'h00;
            endcase
        end
    end

    // Control state, address latch, buffers and registered graphics read
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_cpu_addr  <= '0;
            r_inc2      <= RESET_INC2;
            r_rbuf      <= 8'h00;
            r_wbuf      <= 8'h00;
            r_collision <= 1'b0;
            r_gfx_data  <= 8'h00;
        end else begin
            r_state <= w_state_next;
            if (i_gfx_req) begin
                r_gfx_data <= r_ram[w_ram_idx];
            end
            if (w_fetch) begin
                r_rbuf <= r_ram[w_ram_idx];
            end
            if (w_data_wr && !w_busy) begin
                r_wbuf <= i_sfr_wdata;
            end
            if (w_lo_wr) begin
                r_cpu_addr[7:0] <= i_sfr_wdata;
            end else if (w_hi_wr) begin
                r_cpu_addr[ADDR_W-1:8] <= i_sfr_wdata[ADDR_W-9:0];
            end else if (w_commit || (w_data_rd && !w_busy)) begin
                r_cpu_addr <= w_cpu_inc;
            end
            if (w_hi_wr) begin
                r_inc2 <= i_sfr_wdata[7];
            end
            // A new collision outranks the clear from a STATUS read
            if (w_collide) begin
                r_collision <= 1'b1;
            end else if (w_stat_rd) begin
                r_collision <= 1'b0;
            end
        end
    end

    // RAM write port; a commit coinciding with reset is discarded
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_commit) begin
            r_ram[w_ram_idx] <= r_wbuf;
        end
    end

endmodule

// File: tb/tb_fc8_tilemap_def_port.sv
// Bench for fc8_tilemap_def_port: transaction-level model plus directed literal checks and
// a randomized phase. Honours FC8_TMDEF_VBLANK_LOCK_EN when defined.
module tb_fc8_tilemap_def_port;

`ifdef FC8_TMDEF_VBLANK_LOCK_EN
    localparam bit VbLock = 1'b1;
`else
    localparam bit VbLock = 1'b0;
`endif
    localparam int Depth = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic        gfx_req;
    logic [15:0] gfx_addr;
    logic [7:0]  gfx_data;
    logic        vblank;
    logic        sel;
    logic [1:0]  sreg;
    logic        wr;
    logic        rd;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model: RAM image, address latch, buffers and pending-operation flags
    logic [7:0] m_ram [Depth];
    int         m_addr;
    bit         m_inc2, m_coll, m_wpend, m_rpend;
    logic [7:0] m_rbuf, m_wbuf, m_gfx;

    always #5 clk = ~clk;

    fc8_tilemap_def_port dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_gfx_req  (gfx_req),
        .i_gfx_addr (gfx_addr),
        .o_gfx_data (gfx_data),
        .i_vblank   (vblank),
        .i_sfr_sel  (sel),
        .i_sfr_reg  (sreg),
        .i_sfr_wr   (wr),
        .i_sfr_rd   (rd),
        .i_sfr_wdata(wdata),
        .o_sfr_rdata(rdata),
        .o_busy     (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_rdata();
        logic [7:0] v;
        v = 8'h00;
        if (sel && rd && !wr) begin
            case (sreg)
                2'd0: v = m_addr[7:0];
                2'd1: v = {m_inc2, 4'b0, m_addr[10:8]};
                2'd2: v = m_rbuf;
                default: v = {4'b0, VbLock & vblank, m_inc2, m_coll, m_wpend | m_rpend};
            endcase
        end
        return v;
    endfunction

    task automatic model_step();
        bit old_busy, commit, fetch, w, r;
        int inc;
        if (rst) begin
            m_addr = 0; m_inc2 = 1'b0; m_coll = 1'b0; m_wpend = 1'b0; m_rpend = 1'b0;
            m_rbuf = 8'h00; m_wbuf = 8'h00; m_gfx = 8'h00;
            return;
        end
        old_busy = m_wpend || m_rpend;
        inc = m_inc2 ? 2 : 1;
        if (gfx_req) m_gfx = m_ram[gfx_addr % Depth];
        commit = m_wpend && !gfx_req && (!VbLock || vblank);
        fetch  = m_rpend && !gfx_req;
        if (commit) begin
            m_ram[m_addr] = m_wbuf;
            m_addr = (m_addr + inc) % Depth;
            m_wpend = 1'b0;
            m_rpend = 1'b1;
        end else if (fetch) begin
            m_rbuf = m_ram[m_addr];
            m_rpend = 1'b0;
        end
        w = sel && wr;
        r = sel && rd && !wr;
        if (w) begin
            case (sreg)
                2'd0: m_addr = (m_addr & 32'h700) | int'(wdata);
                2'd1: begin
                    m_addr = (m_addr & 32'hFF) | ((int'(wdata) & 7) << 8);
                    m_inc2 = wdata[7];
                    m_wpend = 1'b0;
                    m_rpend = 1'b1;
                end
                2'd2: begin
                    if (old_busy) m_coll = 1'b1;
                    else begin m_wbuf = wdata; m_wpend = 1'b1; end
                end
                default: ;
            endcase
        end else if (r) begin
            if (sreg == 2'd2) begin
                if (old_busy) m_coll = 1'b1;
                else begin m_addr = (m_addr + inc) % Depth; m_rpend = 1'b1; end
            end else if (sreg == 2'd3) begin
                m_coll = 1'b0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare process: every cycle, away from the active edge
    initial forever begin
        @(negedge clk);
        #2;
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_wpend | m_rpend));
            check("sfr_rdata", 32'(rdata), 32'(exp_rdata()));
            check("gfx_data", 32'(gfx_data), 32'(m_gfx));
        end
    end

    task automatic step(input bit g, input logic [15:0] ga, input bit s, input bit w, input bit r,
                        input logic [1:0] rg, input logic [7:0] wd);
        @(negedge clk);
        gfx_req = g; gfx_addr = ga; sel = s; wr = w; rd = r; sreg = rg; wdata = wd;
        #2;
    endtask

    task automatic idle();
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic sfr_w(input logic [1:0] rg, input logic [7:0] wd);
        step(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, rg, wd);
    endtask

    task automatic sfr_r(input logic [1:0] rg);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, rg, 8'h00);
    endtask

    task automatic gfx_rd(input logic [15:0] a);
        step(1'b1, a, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        idle();
    endtask

    // Counts busy-high samples after an access; gives up past lim
    task automatic wait_idle(input int lim, output int nb);
        nb = 0;
        idle();
        while (busy === 1'b1 && nb <= lim) begin
            nb++;
            idle();
        end
    endtask

    initial begin
        int nb;
        logic [7:0] seq [4];
        rst = 1'b1; gfx_req = 1'b0; gfx_addr = 16'h0; vblank = 1'b0;
        sel = 1'b0; sreg = 2'd0; wr = 1'b0; rd = 1'b0; wdata = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        sfr_r(2'd3);
        check("status_after_reset", 32'(rdata), 32'h00);
        check("busy_after_reset", 32'(busy), 32'h0);
        check("gfx_after_reset", 32'(gfx_data), 32'h00);

        // Preload the whole RAM through the data port
        vblank = 1'b1;
        sfr_w(2'd1, 8'h00);
        sfr_w(2'd0, 8'h00);
        wait_idle(20, nb);
        for (int i = 0; i < Depth; i++) begin
            sfr_w(2'd2, (i == 0) ? 8'hA5 : 8'($urandom));
            wait_idle(2, nb);
            if (nb > 2) check("preload_idle", 32'(nb), 32'd2);
        end
        gfx_rd(16'h0000);
        check("gfx_ram0", 32'(gfx_data), 32'hA5);

        // Sequential writes with INC=1
        seq[0] = 8'h01; seq[1] = 8'h00; seq[2] = 8'h02; seq[3] = 8'h81;
        sfr_w(2'd1, 8'h00);
        sfr_w(2'd0, 8'h00);
        wait_idle(20, nb);
        for (int i = 0; i < 4; i++) begin
            sfr_w(2'd2, seq[i]);
            wait_idle(2, nb);
            check("write_busy_within_2", 32'(nb <= 2), 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            gfx_rd(16'(i));
            check("seq_ram", 32'(gfx_data), 32'(seq[i]));
        end
        sfr_r(2'd0);
        check("addr_lo_after_seq", 32'(rdata), 32'h04);

        // INC2 mode and prefetched read
        sfr_w(2'd1, 8'h80);
        sfr_w(2'd0, 8'h01);
        wait_idle(20, nb);
        sfr_w(2'd2, 8'hC0);
        wait_idle(2, nb);
        sfr_r(2'd0);
        check("addr_lo_inc2", 32'(rdata), 32'h03);
        sfr_r(2'd1);
        check("addr_hi_inc2", 32'(rdata), 32'h80);
        sfr_r(2'd2);
        check("data_read_prefetch", 32'(rdata), 32'h81);
        wait_idle(20, nb);
        gfx_rd(16'h0001);
        check("gfx_ram1", 32'(gfx_data), 32'hC0);

        // Graphics holds the RAM; CPU write waits, second write collides
        vblank = 1'b0;
        sfr_w(2'd1, 8'h00);
        sfr_w(2'd0, 8'h10);
        wait_idle(20, nb);
        sfr_w(2'd2, 8'h55);
        for (int k = 0; k < 10; k++) begin
            if (k == 3)      step(1'b1, 16'h0010, 1'b1, 1'b1, 1'b0, 2'd2, 8'hAA);
            else if (k == 6) step(1'b1, 16'h0010, 1'b1, 1'b0, 1'b1, 2'd3, 8'h00);
            else             step(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
            check("busy_while_gfx", 32'(busy), 32'h1);
            if (k == 6) check("status_collision", 32'(rdata), 32'h03);
        end
        vblank = 1'b1;
        wait_idle(2, nb);
        check("commit_after_gfx", 32'(nb <= 2), 32'd1);
        vblank = 1'b0;
        sfr_r(2'd3);
        check("status_cleared", 32'(rdata), 32'h00);
        vblank = 1'b1;
        gfx_rd(16'h0010);
        check("gfx_ram10", 32'(gfx_data), 32'h55);
        sfr_r(2'd0);
        check("addr_lo_after_drop", 32'(rdata), 32'h11);

        // Address wrap at the top of RAM and graphics address folding
        sfr_w(2'd1, 8'h07);
        sfr_w(2'd0, 8'hFF);
        wait_idle(20, nb);
        sfr_w(2'd2, 8'h3C);
        wait_idle(2, nb);
        sfr_r(2'd0);
        check("addr_lo_wrap", 32'(rdata), 32'h00);
        sfr_r(2'd1);
        check("addr_hi_wrap", 32'(rdata), 32'h00);
        gfx_rd(16'hF7FF);
        check("gfx_fold_7ff", 32'(gfx_data), 32'h3C);

        // Write and read strobes together: write wins, read yields 00
        step(1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 2'd2, 8'h99);
        check("wr_rd_same_cycle", 32'(rdata), 32'h00);
        wait_idle(2, nb);
        gfx_rd(16'h0000);
        check("gfx_wr_wins", 32'(gfx_data), 32'h99);

`ifdef FC8_TMDEF_VBLANK_LOCK_EN
        // Commit held off until vblank
        vblank = 1'b0;
        sfr_w(2'd2, 8'h77);
        for (int k = 0; k < 5; k++) begin
            idle();
            check("vblank_lock_busy", 32'(busy), 32'h1);
        end
        vblank = 1'b1;
        wait_idle(3, nb);
        check("vblank_commit", 32'(nb <= 3), 32'd1);
`endif

        // Randomized traffic, with occasional resets
        for (int c = 0; c < 4000; c++) begin
            bit g, s, w, r;
            logic [1:0] rg;
            g  = ($urandom % 3) == 0;
            s  = ($urandom % 2) == 0;
            w  = ($urandom % 4) == 0;
            r  = ($urandom % 4) == 0;
            rg = 2'($urandom);
            // Address registers are only rewritten while no CPU access is pending
            if (w && rg < 2'd2 && (m_wpend || m_rpend)) w = 1'b0;
            @(negedge clk);
            rst = ($urandom % 400) == 0;
            vblank = 1'($urandom);
            gfx_req = g; gfx_addr = 16'($urandom); sel = s; wr = w; rd = r; sreg = rg;
            wdata = 8'($urandom);
            #2;
        end
        @(negedge clk);
        rst = 1'b0;
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
